// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory block port between the I-cache refill path
// and the D-cache controller; one registered transaction at a time, requesters stalled via busywait.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  I_READ,
    input  logic [ADDR_WIDTH-1:0] I_ADDR,
    output logic [DATA_WIDTH-1:0] I_READDATA,
    output logic                  I_BUSYWAIT,
    input  logic                  D_READ,
    input  logic                  D_WRITE,
    input  logic [ADDR_WIDTH-1:0] D_ADDR,
    input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
    output logic [DATA_WIDTH-1:0] D_READDATA,
    output logic                  D_BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
    input  logic [DATA_WIDTH-1:0] MEM_READDATA,
    input  logic                  MEM_ACK
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_d_q, last_d_d;
    logic                    mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    logic i_req;
    logic d_req;

    assign i_req = I_READ;
    assign d_req = D_READ | D_WRITE;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                // On contention the side that did not go last wins.
                if (i_req && (!d_req || last_d_q)) begin
                    state_d     = GRANT_I;
                    last_d_d    = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = I_ADDR;
                end else if (d_req) begin
                    state_d     = GRANT_D;
                    last_d_d    = 1'b1;
                    mem_read_d  = ~D_WRITE;
                    mem_write_d = D_WRITE;
                    mem_addr_d  = D_ADDR;
                    mem_wdata_d = D_WRITEDATA;
                end
            end
            GRANT_I, GRANT_D: begin
                if (MEM_ACK) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // Busywait drops combinationally in the requester's own ack cycle.
    assign I_BUSYWAIT    = i_req & ~((state_q == GRANT_I) & MEM_ACK);
    assign D_BUSYWAIT    = d_req & ~((state_q == GRANT_D) & MEM_ACK);
    assign I_READDATA    = MEM_READDATA;
    assign D_READDATA    = MEM_READDATA;
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDR      = mem_addr_q;
    assign MEM_WRITEDATA = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level round-robin model.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    logic          CLK = 1'b0;
    logic          RESET, I_READ, D_READ, D_WRITE, MEM_ACK;
    logic [AW-1:0] I_ADDR, D_ADDR, MEM_ADDR;
    logic [DW-1:0] I_READDATA, D_READDATA, D_WRITEDATA, MEM_WRITEDATA, MEM_READDATA;
    logic          I_BUSYWAIT, D_BUSYWAIT, MEM_READ, MEM_WRITE;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: pending requests with their held values, and the side served last.
    bit            pend_i, pend_d, dwr, mdl_last_d, last_win_d;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] dw;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDR(I_ADDR), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDR(D_ADDR), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_ACK(MEM_ACK)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {{(DW-1){1'b0}}, obs}, {{(DW-1){1'b0}}, exp});
    endtask

    task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        chk(tag, {{(DW-AW){1'b0}}, obs}, {{(DW-AW){1'b0}}, exp});
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        return AW'($urandom());
    endfunction

    task automatic check_bus(input string tag, input bit rd, input bit wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] wd);
        chk1({tag, "_rd"}, MEM_READ, rd);
        chk1({tag, "_wr"}, MEM_WRITE, wr);
        chka({tag, "_addr"}, MEM_ADDR, a);
        if (wr) chk({tag, "_wdata"}, MEM_WRITEDATA, wd);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        mdl_last_d = 1'b0;
    endtask

    // One transaction, entered in an IDLE cycle; returns in the IDLE cycle after the ack.
    task automatic run_txn(input int lat, input string tag);
        bit            wd, e_rd, e_wr;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_wd, rdat;
        I_READ      = pend_i;
        I_ADDR      = ia;
        D_READ      = pend_d & !dwr;
        D_WRITE     = pend_d & dwr;
        D_ADDR      = da;
        D_WRITEDATA = dw;
        #1;
        chk1({tag, "_idle_ibw"}, I_BUSYWAIT, pend_i);
        chk1({tag, "_idle_dbw"}, D_BUSYWAIT, pend_d);
        chk1({tag, "_idle_rd"}, MEM_READ, 1'b0);
        chk1({tag, "_idle_wr"}, MEM_WRITE, 1'b0);
        wd   = (pend_i && pend_d) ? !mdl_last_d : pend_d;
        e_rd = wd ? !dwr : 1'b1;
        e_wr = wd ? dwr : 1'b0;
        e_a  = wd ? da : ia;
        e_wd = dw;
        tick();
        // The granted requester changes its inputs; the memory side must not follow.
        if (wd) begin
            D_ADDR      = ~da;
            D_WRITEDATA = '0;
        end else begin
            I_ADDR = ~ia;
        end
        for (int k = 0; k < lat; k++) begin
            check_bus({tag, "_hold"}, e_rd, e_wr, e_a, e_wd);
            chk1({tag, "_hold_ibw"}, I_BUSYWAIT, pend_i);
            chk1({tag, "_hold_dbw"}, D_BUSYWAIT, pend_d);
            tick();
        end
        check_bus({tag, "_ack"}, e_rd, e_wr, e_a, e_wd);
        rdat         = rnd128();
        MEM_READDATA = rdat;
        MEM_ACK      = 1'b1;
        #1;
        if (wd) begin
            chk1({tag, "_ack_dbw"}, D_BUSYWAIT, 1'b0);
            chk({tag, "_ack_drdata"}, D_READDATA, rdat);
            chk1({tag, "_ack_ibw"}, I_BUSYWAIT, pend_i);
        end else begin
            chk1({tag, "_ack_ibw"}, I_BUSYWAIT, 1'b0);
            chk({tag, "_ack_irdata"}, I_READDATA, rdat);
            chk1({tag, "_ack_dbw"}, D_BUSYWAIT, pend_d);
        end
        tick();
        MEM_ACK = 1'b0;
        chk1({tag, "_done_rd"}, MEM_READ, 1'b0);
        chk1({tag, "_done_wr"}, MEM_WRITE, 1'b0);
        if (wd) begin
            pend_d  = 1'b0;
            D_READ  = 1'b0;
            D_WRITE = 1'b0;
        end else begin
            pend_i = 1'b0;
            I_READ = 1'b0;
        end
        mdl_last_d = wd;
        last_win_d = wd;
    endtask

    initial begin
        RESET = 1'b1; I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0; MEM_ACK = 1'b0;
        I_ADDR = '0; D_ADDR = '0; D_WRITEDATA = '0; MEM_READDATA = '0;
        pend_i = 1'b0; pend_d = 1'b0; dwr = 1'b0; ia = '0; da = '0; dw = '0;
        mdl_last_d = 1'b0; last_win_d = 1'b0;

        // Reset state
        tick();
        tick();
        chk1("rst_rd", MEM_READ, 1'b0);
        chk1("rst_wr", MEM_WRITE, 1'b0);
        chka("rst_addr", MEM_ADDR, '0);
        chk("rst_wdata", MEM_WRITEDATA, '0);
        chk1("rst_ibw", I_BUSYWAIT, 1'b0);
        chk1("rst_dbw", D_BUSYWAIT, 1'b0);
        RESET = 1'b0;
        mdl_last_d = 1'b0;

        // Single I-cache read, ack four cycles after MEM_READ rises
        pend_i = 1'b1; ia = 28'h0000010;
        run_txn(4, "t1");

        // Simultaneous requests after reset: D first, then I
        do_reset();
        pend_i = 1'b1; ia = 28'h0000040;
        pend_d = 1'b1; dwr = 1'b0; da = 28'h0000080;
        run_txn(2, "t2_first");
        chk1("t2_first_is_d", last_win_d, 1'b1);
        run_txn(2, "t2_second");
        chk1("t2_second_is_i", last_win_d, 1'b0);

        // Back-to-back D requests with I held: strict alternation
        for (int k = 0; k < 4; k++) begin
            if (!pend_i) begin pend_i = 1'b1; ia = 28'h0000100 + AW'(k); end
            if (!pend_d) begin pend_d = 1'b1; dwr = 1'b0; da = 28'h0000200 + AW'(k); end
            run_txn(1, "t3");
            chk1("t3_alternate", last_win_d, (k % 2 == 0) ? 1'b1 : 1'b0);
        end
        D_READ = 1'b0; pend_d = 1'b0;
        tick();

        // D write; data input cleared after grant
        pend_d = 1'b1; dwr = 1'b1; da = 28'h0000123; dw = {4{32'hA5A5A5A5}};
        run_txn(3, "t4");
        dwr = 1'b0;

        // Reset two cycles into a D read, stray ack afterwards, held request re-arbitrated
        da = 28'h0ABCDEF; D_ADDR = da; D_READ = 1'b1; D_WRITE = 1'b0; I_READ = 1'b0;
        tick();
        chk1("t5_grant_rd", MEM_READ, 1'b1);
        tick();
        RESET = 1'b1;
        tick();
        chk1("t5_rst_rd", MEM_READ, 1'b0);
        chk1("t5_rst_wr", MEM_WRITE, 1'b0);
        RESET = 1'b0;
        MEM_ACK = 1'b1;
        #1;
        chk1("t5_ack_ignored_dbw", D_BUSYWAIT, 1'b1);
        tick();
        MEM_ACK = 1'b0;
        chk1("t5_regrant_rd", MEM_READ, 1'b1);
        chka("t5_regrant_addr", MEM_ADDR, da);
        MEM_READDATA = rnd128();
        MEM_ACK = 1'b1;
        #1;
        chk1("t5_ack_dbw", D_BUSYWAIT, 1'b0);
        tick();
        MEM_ACK = 1'b0; D_READ = 1'b0; pend_d = 1'b0;
        chk1("t5_done_rd", MEM_READ, 1'b0);
        mdl_last_d = 1'b1;

        // Ack in IDLE with no requests
        MEM_ACK = 1'b1;
        #1;
        chk1("t6_ibw", I_BUSYWAIT, 1'b0);
        chk1("t6_dbw", D_BUSYWAIT, 1'b0);
        tick();
        MEM_ACK = 1'b0;
        chk1("t6_rd", MEM_READ, 1'b0);
        chk1("t6_wr", MEM_WRITE, 1'b0);
        pend_i = 1'b1; ia = rnd_addr();
        run_txn(0, "t6_after");

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            if (!pend_i) begin pend_i = 1'($urandom_range(0, 1)); ia = rnd_addr(); end
            if (!pend_d) begin
                pend_d = 1'($urandom_range(0, 1));
                dwr    = 1'($urandom_range(0, 1));
                da     = rnd_addr();
                dw     = rnd128();
            end
            if (!pend_i && !pend_d) pend_i = 1'b1;
            run_txn(int'($urandom_range(0, 5)), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
